// File: rtl/mips_enc_pkg.sv
// Shared definitions for the MIPS instruction encoder/loader.
//   - Opcode constants for every opcode the control unit decodes.
//   - fmt_e:   instruction format classes.
//   - state_e: loader FSM states.
//   - op_format(): opcode -> format classification.
package mips_enc_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_SLTI   = 6'd10;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LB     = 6'd32;
  localparam logic [5:0] OP_LH     = 6'd33;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SB     = 6'd40;
  localparam logic [5:0] OP_SH     = 6'd41;
  localparam logic [5:0] OP_SW     = 6'd43;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILLEGAL} fmt_e;
  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_e;

  function automatic fmt_e op_format(input logic [5:0] op);
    fmt_e f;
    case (op)
      OP_RTYPE:                                  f = FMT_R;
      OP_J, OP_JAL:                              f = FMT_J;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_LB, OP_LH,
      OP_LW, OP_SB, OP_SH, OP_SW:                f = FMT_I;
      default:                                   f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mips_instr_format.sv
// Combinational opcode classification and field packing.
// Ports:
//   opcode, rs, rt, rd, shamt, funct, imm, target : instruction fields
//   word  : packed 32-bit instruction (0 when illegal)
//   legal : opcode is one the control unit decodes
module mips_instr_format
  import mips_enc_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e fmt;

  always_comb begin
    fmt   = op_format(opcode);
    legal = (fmt != FMT_ILLEGAL);
    word  = '0;
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, target};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming instruction encoder/loader: accepts field bundles over
// valid/ready, packs them into R/I/J words and writes them to consecutive
// instruction-memory words starting at a latched base address.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start, base_addr : begin a program load at base_addr
//   in_*             : field bundle handshake (valid/ready/last + fields)
//   mem_we/addr/wdata: instruction-memory write port
//   count            : words written since start
//   busy, done       : FSM status (RUN/WRITE, DONE)
//   err_illegal      : sticky, unsupported opcode dropped
//   err_full         : sticky, write attempted beyond DEPTH
// Optional: define MIPS_ENC_CHECKSUM_EN to add checksum[31:0], the XOR of
// every word written since start.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
`ifdef MIPS_ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic              last_q;
  logic [31:0]       word;
  logic              legal;
  logic              hs;

  assign hs = in_valid & in_ready;

  mips_instr_format u_fmt (
    .opcode (in_opcode),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .funct  (in_funct),
    .imm    (in_imm),
    .target (in_target),
    .word   (word),
    .legal  (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef MIPS_ENC_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            base        <= base_addr;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
`ifdef MIPS_ENC_CHECKSUM_EN
            checksum    <= '0;
`endif
          end
        end
        RUN: begin
          if (hs) begin
            // Full takes priority: the word is dropped regardless of opcode.
            if (count == DEPTH_C) begin
              err_full <= 1'b1;
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (!legal) begin
              err_illegal <= 1'b1;
              if (in_last) begin
                state    <= DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              // Address uses the pre-increment count; truncation gives the wrap.
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= base + count[ADDR_W-1:0];
              mem_wdata <= word;
              last_q    <= in_last;
            end
          end
        end
        WRITE: begin
          count <= count + 1'b1;
`ifdef MIPS_ENC_CHECKSUM_EN
          checksum <= checksum ^ mem_wdata;
`endif
          if (last_q) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Streaming instruction encoder and loader for the single-cycle MIPS core; it is the inverse of the control unit's opcode decode. It accepts instruction fields over a valid/ready handshake, packs them into 32-bit R/I/J words, and writes them sequentially into instruction memory from a base address. It supports only the opcodes the control unit decodes. It is used by the testbench/boot path to load programs before releasing the core.

Parameters:
ADDR_W, 8, word-address width of instruction memory
DEPTH, 256, number of writable words from base (must be <= 2**ADDR_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches base_addr, clears counters/errors, enters RUN
base_addr  in  ADDR_W  first word address
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
in_last  in  1  bundle is final instruction of program
in_opcode  in  6  MIPS opcode
in_rs / in_rt / in_rd / in_shamt  in  5 each  register/shift fields
in_funct  in  6  R-type function
in_imm  in  16  I-type immediate
in_target  in  26  J-type target
mem_we  out  1  instruction-memory write strobe
mem_addr  out  ADDR_W  write address
mem_wdata  out  32  encoded word
count  out  ADDR_W+1  words written since start
busy  out  1  state is RUN or WRITE
done  out  1  high in DONE
err_illegal  out  1  sticky: an unsupported opcode was dropped
err_full  out  1  sticky: write attempted beyond DEPTH

Behaviour:
- Reset: state IDLE; in_ready, mem_we, busy, done, err_* = 0; count = 0; mem_addr/mem_wdata = 0.
- Formats: R (op 0): {op,rs,rt,rd,shamt,funct}. J (op 2,3): {op,target}. I (op 1,4,5,8,10,12,13,14,32,33,35,40,41,43): {op,rs,rt,imm}. Unused fields are ignored. Any other opcode is illegal.
- FSM IDLE -> (start) RUN. RUN: in_ready=1. A handshake (in_valid&in_ready) registers the encoded word and goes to WRITE.
- WRITE: mem_we=1 for exactly one cycle at mem_addr = base+count; count increments; in_ready=0. Next state is DONE if the latched last flag is set, else RUN. Accept-to-write latency is 1 cycle; throughput is 1 word per 2 cycles.
- Illegal opcode on handshake: err_illegal set, no WRITE, count unchanged. Stay in RUN, or go to DONE if in_last.
- Full: handshake with count == DEPTH sets err_full, drops the word and goes to DONE.
- Address wrap: base+count is computed modulo 2**ADDR_W.
- DONE: done=1, in_ready=0. A start pulse re-enters RUN with count and errors cleared.
- start while RUN/WRITE is ignored. reset in any state returns to IDLE next cycle; any pending write is suppressed.

Optional Feature:
Macro MIPS_ENC_CHECKSUM_EN.
- Defined: adds output checksum[31:0]. It is cleared on reset/start and XOR-accumulates mem_wdata on each mem_we cycle, so it is valid in DONE.
- Undefined: no port, no logic.

Decomposition:
- Package mips_enc_pkg: opcode localparams (OP_RTYPE=0, OP_REGIMM=1, OP_J=2, OP_JAL=3, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, ... OP_SW=43), format enum {FMT_R, FMT_I, FMT_J, FMT_ILLEGAL}, FSM state enum {IDLE, RUN, WRITE, DONE}.
- Sub-module mips_instr_format: purely combinational opcode->format classification plus field packing; outputs word[31:0] and legal.

Test Plan:
- start base=0x10; op0 rs1 rt2 rd3 shamt0 funct0x20, last=0 -> mem_we 1 cycle after handshake, addr 0x10, data 0x00221820, count=1.
- op8 rs0 rt8 imm5 then op2 target0x100000 last=1 -> writes 0x20080005 @base, 0x08100000 @base+1; done=1, count=2.
- op35 rs29 rt4 imm8 -> data 0x8FA40008; op43 same fields -> 0xAFA40008.
- op6 (unsupported) -> err_illegal=1, no mem_we, count unchanged; the next legal bundle writes at the same address.
- DEPTH=4, stream 5 words -> 4 writes, 5th sets err_full, done=1; reset asserted during a WRITE cycle -> IDLE, all outputs zero.
- (MIPS_ENC_CHECKSUM_EN) the two-word program above -> checksum = 0x20080005 ^ 0x08100000 = 0x28180005.
